// File: rtl/bus_burst_machine.sv
`default_nettype none
// ============================================================================
//  Module      : bus_burst_machine
//  Description : Burst bus-master handshake FSM on the as_n/ack_n bus with a
//                beat/address counter, a wait-state timeout with an error exit,
//                and an optional read mode selected by macro BUS_RW_READ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_burst_machine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4,
    parameter int BURST_MAX = 8,
    parameter int TO_W      = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_en,
    input  logic              mode,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [ADDR_W-1:0] addr_base,
    input  logic              ack_n,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] addr,
    output logic              as_n,
    output logic              wr_n,
    output logic              counter_ce,
    output logic              stop_n,
    output logic              in_init,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              to_err,
    output logic [2:0]        wr_state
);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_REL  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic             c_to_en   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]  c_to_last = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] c_bmax    = LEN_W'(BURST_MAX);
    localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_beats_left;
    logic [LEN_W-1:0]  w_len;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_rel_first;
    logic              r_to_err;
    logic              w_stall;
    logic              w_to_hit;
    logic              w_last_beat;
    logic              w_rd_mode;

    // Stall cycles are those where the slave has not yet moved the handshake on.
    assign w_stall     = ((r_state == S_ADDR) && ack_n) || ((r_state == S_REL) && !ack_n);
    assign w_to_hit    = c_to_en && w_stall && (r_to_cnt == c_to_last);
    assign w_last_beat = (r_beats_left == c_one);

    always_comb begin
        w_len = burst_len;
        if (burst_len == '0) begin
            w_len = c_one;
        end else if (burst_len > c_bmax) begin
            w_len = c_bmax;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: begin
                if (step_en) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!ack_n) begin
                    w_next = S_REL;
                end else if (w_to_hit) begin
                    w_next = S_ERR;
                end
            end
            S_REL: begin
                if (ack_n) begin
                    w_next = w_last_beat ? S_DONE : S_ADDR;
                end else if (w_to_hit) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_INIT;
            S_ERR:   w_next = S_INIT;
            default: w_next = S_INIT;
        endcase
    end

    // Datapath: address, beat counter, timeout counter, error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_beats_left <= '0;
            r_to_cnt     <= '0;
            r_rel_first  <= 1'b0;
            r_to_err     <= 1'b0;
        end else begin
            r_rel_first <= (r_state == S_ADDR) && !ack_n;
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_stall) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if ((r_state == S_INIT) && step_en) begin
                r_addr       <= addr_base;
                r_beats_left <= w_len;
                r_to_err     <= 1'b0;
            end
            if ((r_state == S_REL) && ack_n && !w_last_beat) begin
                r_addr       <= r_addr + 1'b1;
                r_beats_left <= r_beats_left - 1'b1;
            end
            if (r_state == S_ERR) begin
                r_to_err <= 1'b1;
            end
        end
    end

`ifdef BUS_RW_READ_EN
    logic              r_mode;
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if ((r_state == S_INIT) && step_en) begin
                r_mode <= mode;
            end
            if ((r_state == S_ADDR) && !ack_n && !r_mode) begin
                r_rd_data <= din;
            end
        end
    end

    assign w_rd_mode = !r_mode;
    assign rd_data   = r_rd_data;
`else
    logic w_unused_inputs;

    assign w_unused_inputs = ^{mode, din};
    assign w_rd_mode       = 1'b0;
    assign rd_data         = '0;
`endif

    // Output decode from registered state
    always_comb begin
        as_n       = 1'b1;
        wr_n       = 1'b1;
        counter_ce = 1'b0;
        rd_valid   = 1'b0;
        stop_n     = 1'b1;
        case (r_state)
            S_ADDR: begin
                as_n = 1'b0;
                wr_n = w_rd_mode;
            end
            S_REL: begin
                counter_ce = r_rel_first;
                rd_valid   = r_rel_first && w_rd_mode;
            end
            S_DONE:  stop_n = 1'b0;
            S_ERR:   stop_n = 1'b0;
            default: ;
        endcase
    end

    assign addr     = r_addr;
    assign in_init  = (r_state == S_INIT);
    assign busy     = (r_state != S_INIT);
    assign to_err   = r_to_err;
    assign wr_state = r_state;

endmodule
`default_nettype wire
